// File: rtl/trap_seq.sv
// Trap sequencer: turns ecall/illegal/mret/timer-interrupt retirements into a fixed
// mepc/mcause/mstatus CSR write sequence followed by a handshaked fetch redirect.
module trap_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [DATA_WIDTH-1:0] wb_pc,
   input  logic                  wb_is_ecall,
   input  logic                  wb_is_illegal,
   input  logic                  wb_is_mret,
   input  logic                  irq_timer,
   output logic [ADDR_WIDTH-1:0] csr_raddr,
   input  logic [DATA_WIDTH-1:0] csr_rdata,
   output logic                  csr_wen,
   output logic [ADDR_WIDTH-1:0] csr_waddr,
   output logic [DATA_WIDTH-1:0] csr_wdata,
   output logic                  flush,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ready,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MSTATUS = ADDR_WIDTH'(12'h300);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MTVEC   = ADDR_WIDTH'(12'h305);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC    = ADDR_WIDTH'(12'h341);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE  = ADDR_WIDTH'(12'h342);

   localparam logic [DATA_WIDTH-1:0] CAUSE_TIMER   = {1'b1, (DATA_WIDTH-1)'(7)};
   localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DATA_WIDTH'(11);
   localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE,
      SAVE_EPC,
      SAVE_CAUSE,
      UPD_STATUS,
      RESTORE_STATUS,
      REDIRECT
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   epc_q, epc_d;
   logic [DATA_WIDTH-1:0]   cause_q, cause_d;
   logic                    mret_q, mret_d;
   logic                    flush_q, flush_d;
   logic                    irq_take;

   // mstatus is on the read port in IDLE, so MIE gates the interrupt directly.
   assign irq_take = irq_timer & csr_rdata[3];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         epc_q   <= '0;
         cause_q <= '0;
         mret_q  <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         mret_q  <= mret_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      epc_d          = epc_q;
      cause_d        = cause_q;
      mret_d         = mret_q;
      flush_d        = 1'b0;
      wb_ready       = 1'b0;
      csr_raddr      = ADDR_MSTATUS;
      csr_wen        = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      case (state_q)
         IDLE: begin
            wb_ready = 1'b1;
            if (wb_valid) begin
               if (irq_take || wb_is_ecall || wb_is_illegal) begin
                  epc_d   = wb_pc;
                  mret_d  = 1'b0;
                  flush_d = 1'b1;
                  state_d = SAVE_EPC;
                  if (irq_take)         cause_d = CAUSE_TIMER;
                  else if (wb_is_ecall) cause_d = CAUSE_ECALL;
                  else                  cause_d = CAUSE_ILLEGAL;
               end else if (wb_is_mret) begin
                  mret_d  = 1'b1;
                  flush_d = 1'b1;
                  state_d = RESTORE_STATUS;
               end
            end
         end
         SAVE_EPC: begin
            csr_wen   = 1'b1;
            csr_waddr = ADDR_MEPC;
            csr_wdata = epc_q;
            state_d   = SAVE_CAUSE;
         end
         SAVE_CAUSE: begin
            csr_wen   = 1'b1;
            csr_waddr = ADDR_MCAUSE;
            csr_wdata = cause_q;
            state_d   = UPD_STATUS;
         end
         UPD_STATUS: begin
            csr_wen          = 1'b1;
            csr_waddr        = ADDR_MSTATUS;
            csr_wdata        = csr_rdata;
            csr_wdata[7]     = csr_rdata[3];
            csr_wdata[3]     = 1'b0;
            csr_wdata[12:11] = 2'b11;
            state_d          = REDIRECT;
         end
         RESTORE_STATUS: begin
            csr_wen          = 1'b1;
            csr_waddr        = ADDR_MSTATUS;
            csr_wdata        = csr_rdata;
            csr_wdata[3]     = csr_rdata[7];
            csr_wdata[7]     = 1'b1;
            csr_wdata[12:11] = 2'b11;
            state_d          = REDIRECT;
         end
         REDIRECT: begin
            // No CSR writes here, so the target read stays stable while stalled.
            csr_raddr      = mret_q ? ADDR_MEPC : ADDR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign flush = flush_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: a small CSR file model answers reads and absorbs writes,
// and each task walks one scenario cycle by cycle against hand-computed values.
module tb_trap_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_pc;
   logic        wb_is_ecall, wb_is_illegal, wb_is_mret, irq_timer;
   logic [11:0] csr_raddr, csr_waddr;
   logic [31:0] csr_rdata, csr_wdata;
   logic        csr_wen, flush, redirect_valid, redirect_ready, busy;
   logic [31:0] redirect_pc;

   logic [31:0] m_status = 32'h0, m_tvec = 32'h0, m_epc = 32'h0, m_cause = 32'h0;
   logic        tb_wen;
   logic [11:0] tb_waddr;
   logic [31:0] tb_wdata;

   int checks = 0;
   int failures = 0;

   trap_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
      .wb_is_ecall(wb_is_ecall), .wb_is_illegal(wb_is_illegal), .wb_is_mret(wb_is_mret),
      .irq_timer(irq_timer),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (csr_raddr)
         12'h300: csr_rdata = m_status;
         12'h305: csr_rdata = m_tvec;
         12'h341: csr_rdata = m_epc;
         12'h342: csr_rdata = m_cause;
         default: csr_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (csr_wen) begin
         case (csr_waddr)
            12'h300: m_status <= csr_wdata;
            12'h305: m_tvec   <= csr_wdata;
            12'h341: m_epc    <= csr_wdata;
            12'h342: m_cause  <= csr_wdata;
            default: ;
         endcase
      end else if (tb_wen) begin
         case (tb_waddr)
            12'h300: m_status <= tb_wdata;
            12'h305: m_tvec   <= tb_wdata;
            12'h341: m_epc    <= tb_wdata;
            12'h342: m_cause  <= tb_wdata;
            default: ;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      tb_wen = 1'b1; tb_waddr = a; tb_wdata = d;
      step();
      tb_wen = 1'b0;
   endtask

   task automatic present(input logic [31:0] pc, input logic ec, input logic il,
                          input logic mr, input logic irq);
      wb_valid = 1'b1; wb_pc = pc; wb_is_ecall = ec; wb_is_illegal = il;
      wb_is_mret = mr; irq_timer = irq;
   endtask

   task automatic clear_wb();
      wb_valid = 1'b0; wb_is_ecall = 1'b0; wb_is_illegal = 1'b0;
      wb_is_mret = 1'b0; irq_timer = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(); step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
      checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== 45'h0) begin failures++;
         $display("FAIL reset_csr got=%b/%h/%h exp=0/000/00000000", csr_wen, csr_waddr, csr_wdata); end
      rst = 1'b1;
      step();
      $display("txn reset done");
   endtask

   task automatic test_ecall();
      poke(12'h300, 32'h0000_1808);
      poke(12'h305, 32'h8000_1003);
      present(32'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL ecall_T_ready got=%b exp=1", wb_ready); end
      step(); clear_wb();
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ecall_T1_flush got=%b exp=1", flush); end
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h341, 32'h8000_0010}) begin failures++;
         $display("FAIL ecall_T1_mepc got=%b/%h/%h exp=1/341/80000010", csr_wen, csr_waddr, csr_wdata); end
      checks++; if ({busy, wb_ready} !== 2'b10) begin failures++; $display("FAIL ecall_T1_busy got=%b%b exp=10", busy, wb_ready); end
      step();
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL ecall_T2_flush got=%b exp=0", flush); end
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h342, 32'h0000_000b}) begin failures++;
         $display("FAIL ecall_T2_mcause got=%b/%h/%h exp=1/342/0000000b", csr_wen, csr_waddr, csr_wdata); end
      step();
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h300, 32'h0000_1880}) begin failures++;
         $display("FAIL ecall_T3_mstatus got=%b/%h/%h exp=1/300/00001880", csr_wen, csr_waddr, csr_wdata); end
      step();
      checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_1000}) begin failures++;
         $display("FAIL ecall_T4_redirect got=%b/%h exp=1/80001000", redirect_valid, redirect_pc); end
      checks++; if ({csr_wen, flush} !== 2'b00) begin failures++; $display("FAIL ecall_T4_wen_flush got=%b%b exp=00", csr_wen, flush); end
      step();
      checks++; if ({busy, wb_ready, redirect_valid} !== 3'b010) begin failures++;
         $display("FAIL ecall_T5_idle got=%b%b%b exp=010", busy, wb_ready, redirect_valid); end
      $display("txn ecall pc=80000010 mepc=%h mcause=%h mstatus=%h", m_epc, m_cause, m_status);
   endtask

   task automatic test_mret();
      poke(12'h341, 32'h8000_0014);
      present(32'h8000_0050, 1'b0, 1'b0, 1'b1, 1'b0);
      step(); clear_wb();
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mret_T1_flush got=%b exp=1", flush); end
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h300, 32'h0000_1888}) begin failures++;
         $display("FAIL mret_T1_mstatus got=%b/%h/%h exp=1/300/00001888", csr_wen, csr_waddr, csr_wdata); end
      step();
      checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0014}) begin failures++;
         $display("FAIL mret_T2_redirect got=%b/%h exp=1/80000014", redirect_valid, redirect_pc); end
      step();
      checks++; if ({busy, wb_ready} !== 2'b01) begin failures++; $display("FAIL mret_T3_idle got=%b%b exp=01", busy, wb_ready); end
      $display("txn mret mstatus=%h", m_status);
   endtask

   task automatic test_irq();
      // mstatus is 0x1888 here, so MIE=1; irq and wb_valid stay high across the sequence.
      present(32'h8000_0020, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h341, 32'h8000_0020}) begin failures++;
         $display("FAIL irq_T1_mepc got=%b/%h/%h exp=1/341/80000020", csr_wen, csr_waddr, csr_wdata); end
      step();
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h342, 32'h8000_0007}) begin failures++;
         $display("FAIL irq_T2_mcause got=%b/%h/%h exp=1/342/80000007", csr_wen, csr_waddr, csr_wdata); end
      checks++; if ({flush, wb_ready} !== 2'b00) begin failures++; $display("FAIL irq_T2_retake got=%b%b exp=00", flush, wb_ready); end
      step();
      checks++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h300, 32'h0000_1880}) begin failures++;
         $display("FAIL irq_T3_mstatus got=%b/%h/%h exp=1/300/00001880", csr_wen, csr_waddr, csr_wdata); end
      step(); clear_wb();
      checks++; if ({redirect_valid, redirect_pc, flush} !== {1'b1, 32'h8000_1000, 1'b0}) begin failures++;
         $display("FAIL irq_T4_redirect got=%b/%h/%b exp=1/80001000/0", redirect_valid, redirect_pc, flush); end
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL irq_T5_idle got=%b exp=0", busy); end
      $display("txn irq pc=80000020 mepc=%h mcause=%h", m_epc, m_cause);
   endtask

   task automatic test_stall();
      redirect_ready = 1'b0;
      present(32'h8000_0030, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); clear_wb();
      step(); step(); step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({redirect_valid, redirect_pc, wb_ready, csr_wen} !== {1'b1, 32'h8000_1000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stall_hold%0d got=%b/%h/%b/%b exp=1/80001000/0/0", i, redirect_valid, redirect_pc, wb_ready, csr_wen);
         end
         step();
      end
      redirect_ready = 1'b1;
      checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL stall_release_rv got=%b exp=1", redirect_valid); end
      step();
      checks++; if ({busy, wb_ready} !== 2'b01) begin failures++; $display("FAIL stall_idle got=%b%b exp=01", busy, wb_ready); end
      $display("txn stall 5 cycles mepc=%h", m_epc);
   endtask

   task automatic test_reset_mid();
      poke(12'h300, 32'h0000_1808);
      present(32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); clear_wb();
      step();
      rst = 1'b0;
      step();
      checks++; if ({busy, csr_wen, flush, redirect_valid, wb_ready} !== 5'b00001) begin failures++;
         $display("FAIL rstmid_T3 got=%b%b%b%b%b exp=00001", busy, csr_wen, flush, redirect_valid, wb_ready); end
      rst = 1'b1;
      step();
      checks++; if (m_status !== 32'h0000_1808) begin failures++; $display("FAIL rstmid_nowrite got=%h exp=00001808", m_status); end
      present(32'h8000_0050, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); clear_wb();
      checks++; if ({flush, csr_wen, csr_waddr, csr_wdata} !== {2'b11, 12'h341, 32'h8000_0050}) begin failures++;
         $display("FAIL rstmid_again_T1 got=%b%b/%h/%h exp=11/341/80000050", flush, csr_wen, csr_waddr, csr_wdata); end
      step();
      checks++; if ({csr_waddr, csr_wdata} !== {12'h342, 32'h0000_000b}) begin failures++;
         $display("FAIL rstmid_again_T2 got=%h/%h exp=342/0000000b", csr_waddr, csr_wdata); end
      step();
      checks++; if ({csr_waddr, csr_wdata} !== {12'h300, 32'h0000_1880}) begin failures++;
         $display("FAIL rstmid_again_T3 got=%h/%h exp=300/00001880", csr_waddr, csr_wdata); end
      step();
      checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_1000}) begin failures++;
         $display("FAIL rstmid_again_T4 got=%b/%h exp=1/80001000", redirect_valid, redirect_pc); end
      step();
      $display("txn reset_mid then ecall pc=80000050 mstatus=%h", m_status);
   endtask

   task automatic test_priority();
      // Illegal beats mret; mstatus is 0x1880 so MIE=0 afterwards.
      present(32'h8000_0060, 1'b0, 1'b1, 1'b1, 1'b0);
      step(); clear_wb();
      checks++; if (csr_waddr !== 12'h341) begin failures++; $display("FAIL prio_il_T1 got=%h exp=341", csr_waddr); end
      step();
      checks++; if (csr_wdata !== 32'h0000_0002) begin failures++; $display("FAIL prio_il_cause got=%h exp=00000002", csr_wdata); end
      step(); step();
      checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_1000}) begin failures++;
         $display("FAIL prio_il_redirect got=%b/%h exp=1/80001000", redirect_valid, redirect_pc); end
      step();
      present(32'h8000_0064, 1'b1, 1'b0, 1'b1, 1'b0);
      step(); clear_wb(); step();
      checks++; if ({csr_waddr, csr_wdata} !== {12'h342, 32'h0000_000b}) begin failures++;
         $display("FAIL prio_ecall_mret got=%h/%h exp=342/0000000b", csr_waddr, csr_wdata); end
      step(); step(); step();
      $display("txn priority checks done mstatus=%h", m_status);
   endtask

   task automatic test_irq_masked();
      // mstatus is 0x1800: MIE=0, so the timer must not fire.
      present(32'h8000_0070, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL masked_ready got=%b exp=1", wb_ready); end
      step();
      checks++; if ({busy, flush, csr_wen} !== 3'b000) begin failures++;
         $display("FAIL masked_notaken got=%b%b%b exp=000", busy, flush, csr_wen); end
      step(); clear_wb();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL masked_busy2 got=%b exp=0", busy); end
      $display("txn irq masked pc=80000070");
   endtask

   initial begin
      rst = 1'b0; redirect_ready = 1'b1; tb_wen = 1'b0; tb_waddr = 12'h0; tb_wdata = 32'h0;
      wb_pc = 32'h0;
      clear_wb();
      test_reset();
      test_ecall();
      test_mret();
      test_irq();
      test_stall();
      test_reset_mid();
      test_priority();
      test_irq_masked();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
